mac_accum16s: RTL and testbench

//  Downstream consumer of the clocked 8u x 8s multiplier: sums a block of LEN signed 16-bit

---
 rtl/mac_accum16s_pkg.sv | 14 +
 rtl/mac_accum16s_sat_shift.sv | 32 +++
 rtl/mac_accum16s.sv | 126 ++++++++++++
 tb/tb_mac_accum16s.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_accum16s_pkg.sv
// Shared types and default widths for the block multiply-accumulate unit.
package mac_accum16s_pkg;

  localparam int unsigned DefInW  = 16;
  localparam int unsigned DefAccW = 24;
  localparam int unsigned DefOutW = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StHold = 2'd2
  } state_e;

endpackage

// File: rtl/mac_accum16s_sat_shift.sv
// Arithmetic right shift of the accumulator followed by clamping to the output range.
module mac_accum16s_sat_shift #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 0
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] value,
  output logic             sat
);

  logic signed [ACC_W-1:0] s;
  logic signed [ACC_W-1:0] max_ext;
  logic signed [ACC_W-1:0] min_ext;

  assign s       = $signed(acc) >>> SHIFT;
  assign max_ext = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  assign min_ext = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    value = s[OUT_W-1:0];
    sat   = 1'b0;
    if (s > max_ext) begin
      value = {1'b0, {(OUT_W-1){1'b1}}};
      sat   = 1'b1;
    end else if (s < min_ext) begin
      value = {1'b1, {(OUT_W-1){1'b0}}};
      sat   = 1'b1;
    end
  end

endmodule

// File: rtl/mac_accum16s.sv
// Sums a block of signed products, then scales, saturates and hands the result to a sink.
module mac_accum16s
  import mac_accum16s_pkg::*;
#(
  parameter int unsigned IN_W  = DefInW,
  parameter int unsigned ACC_W = DefAccW,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned OUT_W = DefOutW,
  parameter int unsigned SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             prod_valid,
  input  logic [IN_W-1:0]  prod,
  output logic             busy,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [OUT_W-1:0] sum,
  output logic             acc_ovf,
  output logic             sat
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [OUT_W-1:0]   sum_q, sum_d;
  logic               sat_q, sat_d;

  logic [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]   acc_add;
  logic               add_ovf;
  logic [OUT_W-1:0]   sh_value;
  logic               sh_sat;
  logic               accept_start;

  assign addend  = ACC_W'($signed(prod));
  assign acc_add = acc_q + addend;
  // Wrap occurs only when both operands share a sign that the result does not.
  assign add_ovf = (acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                   (acc_add[ACC_W-1] != acc_q[ACC_W-1]);

  // Scaled from the post-add value so the result is registered on the final product edge.
  mac_accum16s_sat_shift #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_sat_shift (
    .acc   (acc_add),
    .value (sh_value),
    .sat   (sh_sat)
  );

  assign accept_start = start && ((state_q == StIdle) || ((state_q == StHold) && sum_ready));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    sat_d   = sat_q;

    case (state_q)
      StIdle: ;
      StAcc: begin
        if (prod_valid) begin
          acc_d = acc_add;
          cnt_d = cnt_q - 1'b1;
          ovf_d = ovf_q | add_ovf;
          if (cnt_q == LEN_W'(1)) begin
            state_d = StHold;
            sum_d   = sh_value;
            sat_d   = sh_sat;
          end
        end
      end
      StHold: begin
        if (sum_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Back-to-back start in the handshake cycle follows the idle rules.
    if (accept_start) begin
      acc_d = '0;
      ovf_d = 1'b0;
      if (len != '0) begin
        cnt_d   = len;
        state_d = StAcc;
      end else begin
        cnt_d   = '0;
        sum_d   = '0;
        sat_d   = 1'b0;
        state_d = StHold;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
    end
  end

  assign busy      = (state_q == StAcc);
  assign sum_valid = (state_q == StHold);
  assign sum       = sum_q;
  assign acc_ovf   = ovf_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_mac_accum16s.sv
// Scoreboard bench: two instances (24- and 16-bit accumulators) share stimulus.
module tb_mac_accum16s;

  localparam int SHIFT = 0;

  typedef struct packed {
    logic [15:0] sum;
    logic        ovf;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        prod_valid;
  logic [15:0] prod;
  logic        sum_ready;

  logic        busy24, sv24, ovf24, sat24;
  logic [15:0] sum24;
  logic        busy16, sv16, ovf16, sat16;
  logic [15:0] sum16;

  int checks = 0;
  int failures = 0;

  exp_t q24[$];
  exp_t q16[$];

  always #5 clk = ~clk;

  mac_accum16s #(.ACC_W(24)) dut24 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod       (prod),
    .busy       (busy24),
    .sum_valid  (sv24),
    .sum_ready  (sum_ready),
    .sum        (sum24),
    .acc_ovf    (ovf24),
    .sat        (sat24)
  );

  mac_accum16s #(.ACC_W(16)) dut16 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod       (prod),
    .busy       (busy16),
    .sum_valid  (sv16),
    .sum_ready  (sum_ready),
    .sum        (sum16),
    .acc_ovf    (ovf16),
    .sat        (sat16)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: wrap-around sum of a block, sticky overflow, shift, clamp.
  function automatic exp_t model(input logic [15:0] p[$], input int w);
    longint acc = 0;
    longint hi = (64'sd1 <<< (w - 1)) - 1;
    longint lo = -(64'sd1 <<< (w - 1));
    longint s;
    exp_t e;
    e.ovf = 1'b0;
    foreach (p[i]) begin
      acc += longint'($signed(p[i]));
      if (acc > hi) begin
        acc -= (64'sd1 <<< w);
        e.ovf = 1'b1;
      end else if (acc < lo) begin
        acc += (64'sd1 <<< w);
        e.ovf = 1'b1;
      end
    end
    s = acc >>> SHIFT;
    if (s > 32767) begin
      e.sum = 16'h7fff; e.sat = 1'b1;
    end else if (s < -32768) begin
      e.sum = 16'h8000; e.sat = 1'b1;
    end else begin
      e.sum = 16'(s); e.sat = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [15:0] mul(input int a, input int b);
    return 16'(a * b);
  endfunction

  task automatic cmp(input string nm, input logic [15:0] s, input logic o, input logic t,
                     input exp_t e);
    chk({nm, "_sum"}, 32'(s), 32'(e.sum));
    chk({nm, "_ovf"}, 32'(o), 32'(e.ovf));
    chk({nm, "_sat"}, 32'(t), 32'(e.sat));
  endtask

  // Monitor: compares every presented result against the queue head; pops on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (sv24) begin
        if (q24.size() == 0) chk("unexpected_valid24", 32'(q24.size()), 32'd1);
        else begin
          cmp("dut24", sum24, ovf24, sat24, q24[0]);
          if (sum_ready) void'(q24.pop_front());
        end
      end
      if (sv16) begin
        if (q16.size() == 0) chk("unexpected_valid16", 32'(q16.size()), 32'd1);
        else begin
          cmp("dut16", sum16, ovf16, sat16, q16[0]);
          if (sum_ready) void'(q16.pop_front());
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] p[$]);
    q24.push_back(model(p, 24));
    q16.push_back(model(p, 16));
  endtask

  // gap < 0 selects a random 0..2 idle cycles before each product.
  task automatic feed(input logic [15:0] p[$], input int gap);
    foreach (p[i]) begin
      int g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        prod_valid = 1'b0;
        prod       = 16'($urandom);
        sum_ready  = 1'($urandom);
        cycle();
        chk("busy_in_gap", 32'(busy24), 32'd1);
      end
      prod_valid = 1'b1;
      prod       = p[i];
      cycle();
    end
    prod_valid = 1'b0;
    chk("latency_valid24", 32'(sv24), 32'd1);
    chk("latency_valid16", 32'(sv16), 32'd1);
    chk("busy_after_last", 32'(busy24), 32'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      sum_ready = ($urandom_range(0, 2) != 0);
      if (sv24 && sum_ready) begin
        cycle();
        sum_ready = 1'b0;
        chk("valid_drop", 32'(sv24), 32'd0);
        return;
      end
      cycle();
    end
    chk("drain_timeout", 32'(sv24), 32'd0);
  endtask

  task automatic do_block(input logic [15:0] p[$], input int gap);
    sum_ready = 1'b0;
    start     = 1'b1;
    len       = 8'(p.size());
    push_exp(p);
    cycle();
    start = 1'b0;
    chk("busy_after_start", 32'(busy24), 32'(p.size() != 0));
    if (p.size() != 0) feed(p, gap);
    else chk("len0_valid", 32'(sv24), 32'd1);
    wait_done();
  endtask

  initial begin
    logic [15:0] p[$];
    rst = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0; sum_ready = 1'b0;
    repeat (3) cycle();
    chk("rst_busy", 32'(busy24), 32'd0);
    chk("rst_valid", 32'(sv24), 32'd0);
    chk("rst_sum", 32'(sum24), 32'd0);
    chk("rst_flags", {ovf24, sat24, ovf16, sat16}, 32'd0);
    rst = 1'b0;
    // Prod_valid ignored while idle.
    prod_valid = 1'b1; prod = 16'h1234;
    cycle();
    prod_valid = 1'b0;
    chk("idle_ignore", 32'({busy24, sv24}), 32'd0);

    p = '{16'h1c39, 16'h1c39, 16'h1c39, 16'h1c39};
    do_block(p, 1);
    p = '{16'h8080, 16'hffab};
    do_block(p, 0);
    p = '{16'h7f01, 16'h7f01};
    do_block(p, 0);
    p = {};
    do_block(p, 0);

    // Hold under backpressure with noise, then back-to-back start.
    p = '{mul(200, -100), mul(13, 77)};
    sum_ready = 1'b0; start = 1'b1; len = 8'd2;
    push_exp(p);
    cycle();
    start = 1'b0;
    feed(p, 0);
    for (int i = 0; i < 5; i++) begin
      sum_ready  = 1'b0;
      prod_valid = ~prod_valid;
      prod       = 16'($urandom);
      start      = (i == 2);
      len        = 8'd3;
      cycle();
      chk("hold_valid", 32'(sv24), 32'd1);
      chk("hold_busy", 32'(busy24), 32'd0);
    end
    prod_valid = 1'b0;
    p = '{mul(255, -128)};
    sum_ready = 1'b1; start = 1'b1; len = 8'd1;
    push_exp(p);
    cycle();
    start = 1'b0; sum_ready = 1'b0;
    chk("b2b_busy", 32'(busy24), 32'd1);
    chk("b2b_valid", 32'(sv24), 32'd0);
    feed(p, 0);
    wait_done();

    // Reset mid-block discards the partial sum.
    start = 1'b1; len = 8'd4;
    cycle();
    start = 1'b0;
    prod_valid = 1'b1; prod = 16'h1000;
    cycle();
    cycle();
    prod_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy24), 32'd0);
    chk("midrst_valid", 32'(sv24), 32'd0);
    cycle();
    chk("midrst_valid2", 32'(sv24), 32'd0);
    p = '{16'h0100};
    do_block(p, 0);

    // Random blocks; some with large same-sign products to drive saturation and wrap.
    for (int b = 0; b < 30; b++) begin
      int n = (b % 5 == 4) ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 10));
      bit big = (b % 3 == 0);
      bit neg = 1'($urandom);
      p = {};
      for (int k = 0; k < n; k++) begin
        if (big) p.push_back(mul($urandom_range(200, 255),
                                 neg ? -int'($urandom_range(100, 128))
                                     : int'($urandom_range(100, 127))));
        else p.push_back(mul($urandom_range(0, 255), int'($urandom_range(0, 255)) - 128));
      end
      do_block(p, -1);
    end

    repeat (2) cycle();
    chk("q24_empty", 32'(q24.size()), 32'd0);
    chk("q16_empty", 32'(q16.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
